// File: rtl/mult_arbiter.sv
// Round-robin sharing of one 4x4 multiplier between two valid/ready requesters.
// Accept -> product registered one cycle later; response held until consumed; requests wait while busy.

module multiplier_comb (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  assign p = {4'b0000, a} * {4'b0000, b};
endmodule

module mult_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [2*WIDTH-1:0] rsp0_p,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [2*WIDTH-1:0] rsp1_p,
  output logic               busy,
  output logic               grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d;
  logic [WIDTH-1:0]     op_b_q, op_b_d;
  logic                 grant_id_q, grant_id_d;
  logic                 last_grant_q, last_grant_d;
  logic                 rsp0_valid_q, rsp0_valid_d;
  logic                 rsp1_valid_q, rsp1_valid_d;
  logic [2*WIDTH-1:0]   rsp0_p_q, rsp0_p_d;
  logic [2*WIDTH-1:0]   rsp1_p_q, rsp1_p_d;

  logic [2*WIDTH-1:0]   prod;
  logic                 winner;
  logic                 accept;
  logic                 rsp_hs;

  // The shared multiplier only ever sees the registered operands.
  multiplier_comb u_mult (
    .a (op_a_q),
    .b (op_b_q),
    .p (prod)
  );

  // On a tie the requester not served last time wins; otherwise the lone valid wins.
  assign winner = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign accept = (state_q == IDLE) & (req0_valid | req1_valid);
  assign rsp_hs = grant_id_q ? (rsp1_valid_q & rsp1_ready) : (rsp0_valid_q & rsp0_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_p_q     <= '0;
      rsp1_p_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_p_q     <= rsp0_p_d;
      rsp1_p_q     <= rsp1_p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_p_d     = rsp0_p_q;
    rsp1_p_d     = rsp1_p_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d     = winner ? req1_a : req0_a;
          op_b_d     = winner ? req1_b : req0_b;
          grant_id_d = winner;
        end
      end
      CALC: begin
        if (grant_id_q) begin
          rsp1_p_d     = prod;
          rsp1_valid_d = 1'b1;
        end else begin
          rsp0_p_d     = prod;
          rsp0_valid_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          last_grant_d = grant_id_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == IDLE) & req0_valid & ~winner;
    req1_ready = (state_q == IDLE) & req1_valid & winner;
    busy       = (state_q != IDLE);
    grant_id   = grant_id_q;
    rsp0_valid = rsp0_valid_q;
    rsp1_valid = rsp1_valid_q;
    rsp0_p     = rsp0_p_q;
    rsp1_p     = rsp1_p_q;
  end

endmodule
